// File: rtl/io_access_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : io_access_sequencer
// Purpose  : Multi-cycle sequencer between the CPU's single-cycle IORead /
//            IOWrite strobes and the shared peripheral bus. It decodes the
//            target device from the low 10 bits of an IO-space address and
//            runs a select / strobe / ready handshake. While the access is in
//            progress it stalls the CPU. It returns load data to write-back.
// Ports    : clock, reset (async, active-low)
//            IORead, IOWrite, Addr_low[9:0], Wdata[31:0]   - CPU request
//            Stall, Rdata[31:0]                            - CPU response
//            Dev_sel[NUM_DEV-1:0], Dev_addr[DEV_SHIFT-3:0],
//            Dev_wdata[31:0], Dev_rd, Dev_wr               - bus request
//            Dev_rdata[31:0], Dev_ready                    - bus response
//            Bus_error                                     - one-cycle fault
// Options  : IO_TIMEOUT_EN - when defined, abort WAIT to ERR after TIMEOUT
//            cycles without Dev_ready.
// Revision : 1.0 - initial release
// ============================================================================
module io_access_sequencer #(
    parameter int NUM_DEV   = 8,
    parameter int DEV_SHIFT = 4,
    parameter int TIMEOUT   = 15
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   IORead,
    input  logic                   IOWrite,
    input  logic [9:0]             Addr_low,
    input  logic [31:0]            Wdata,
    input  logic [31:0]            Dev_rdata,
    input  logic                   Dev_ready,
    output logic                   Stall,
    output logic [31:0]            Rdata,
    output logic [NUM_DEV-1:0]     Dev_sel,
    output logic [DEV_SHIFT-3:0]   Dev_addr,
    output logic [31:0]            Dev_wdata,
    output logic                   Dev_rd,
    output logic                   Dev_wr,
    output logic                   Bus_error
);

    localparam int c_IDX_W = 10 - DEV_SHIFT;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_WAIT  = 3'd2,
        S_DONE  = 3'd3,
        S_ERR   = 3'd4
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;
    logic [c_IDX_W-1:0]     r_idx;
    logic [DEV_SHIFT-3:0]   r_word;
    logic [31:0]            r_wdata;
    logic                   r_is_read;
    logic [31:0]            r_rdata;

    logic                   w_req;
    logic [c_IDX_W-1:0]     w_idx;
    logic                   w_bad;
    logic                   w_timeout;
    logic                   w_err_read;

    assign w_req = IORead | IOWrite;
    assign w_idx = Addr_low[9:DEV_SHIFT];
    assign w_bad = (32'(w_idx) >= NUM_DEV) || (Addr_low[1:0] != 2'b00) || (IORead && IOWrite);

    // A fault raised straight from IDLE takes its direction from the live
    // request; a fault raised from WAIT uses the latched direction.
    assign w_err_read = (r_state == S_IDLE) ? IORead : r_is_read;

`ifdef IO_TIMEOUT_EN
    localparam int                c_CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_MAX  = c_CNT_W'(TIMEOUT);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT - 1);

    logic [c_CNT_W-1:0] r_cnt;

    // Held at zero outside WAIT, so it is clear on every WAIT entry.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (r_state != S_WAIT) begin
            r_cnt <= '0;
        end else if (r_cnt != c_CNT_MAX) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // The count reaches TIMEOUT at the end of this cycle: this is the last
    // WAIT cycle allowed.
    assign w_timeout = (r_state == S_WAIT) && (r_cnt == c_CNT_LAST);
`else
    logic w_unused_timeout;
    assign w_unused_timeout = (TIMEOUT != 0);
    assign w_timeout        = 1'b0;
`endif

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_req) begin
                    w_state_next = w_bad ? S_ERR : S_SETUP;
                end
            end
            S_SETUP: w_state_next = S_WAIT;
            S_WAIT: begin
                // Ready wins over a simultaneous timeout.
                if (Dev_ready) begin
                    w_state_next = S_DONE;
                end else if (w_timeout) begin
                    w_state_next = S_ERR;
                end
            end
            // DONE never re-accepts the retiring instruction's request.
            S_DONE:  w_state_next = S_IDLE;
            S_ERR:   w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        Stall     = 1'b0;
        Dev_sel   = '0;
        Dev_rd    = 1'b0;
        Dev_wr    = 1'b0;
        Bus_error = 1'b0;
        case (r_state)
            // Combinational so the requester freezes in its own cycle; gated
            // by reset so every output is low while reset is held.
            S_IDLE:  Stall = w_req & reset;
            S_SETUP: begin
                Stall   = 1'b1;
                Dev_sel = {{(NUM_DEV-1){1'b0}}, 1'b1} << r_idx;
            end
            S_WAIT: begin
                Stall   = 1'b1;
                Dev_sel = {{(NUM_DEV-1){1'b0}}, 1'b1} << r_idx;
                Dev_rd  = r_is_read;
                Dev_wr  = ~r_is_read;
            end
            S_ERR:   Bus_error = 1'b1;
            default: Stall = 1'b0;
        endcase
    end

    assign Dev_addr  = r_word;
    assign Dev_wdata = r_wdata;
    assign Rdata     = r_rdata;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_idx     <= '0;
            r_word    <= '0;
            r_wdata   <= '0;
            r_is_read <= 1'b0;
            r_rdata   <= '0;
        end else begin
            r_state <= w_state_next;
            if (r_state == S_IDLE && w_req) begin
                r_idx     <= w_idx;
                r_word    <= Addr_low[DEV_SHIFT-1:2];
                r_wdata   <= Wdata;
                r_is_read <= IORead;
            end
            // Load data is registered on the way into DONE or ERR, so it is
            // valid in the cycle the instruction retires.
            if (r_state == S_WAIT && Dev_ready && r_is_read) begin
                r_rdata <= Dev_rdata;
            end else if (w_state_next == S_ERR && w_err_read) begin
                r_rdata <= 32'hFFFF_FFFF;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_io_access_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_io_access_sequencer
// Purpose  : Directed self-checking bench for io_access_sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_io_access_sequencer;

    logic        clock = 1'b0;
    logic        reset;
    logic        IORead, IOWrite, Dev_ready;
    logic [9:0]  Addr_low;
    logic [31:0] Wdata, Dev_rdata;
    logic        Stall, Dev_rd, Dev_wr, Bus_error;
    logic [31:0] Rdata, Dev_wdata;
    logic [7:0]  Dev_sel;
    logic [1:0]  Dev_addr;

    int n_cmp = 0;
    int n_bad = 0;
    logic [11:0] obs;   // {Stall, Dev_rd, Dev_wr, Bus_error, Dev_sel}

    io_access_sequencer #(.NUM_DEV(8), .DEV_SHIFT(4), .TIMEOUT(15)) dut (
        .clock(clock), .reset(reset), .IORead(IORead), .IOWrite(IOWrite),
        .Addr_low(Addr_low), .Wdata(Wdata), .Dev_rdata(Dev_rdata),
        .Dev_ready(Dev_ready), .Stall(Stall), .Rdata(Rdata), .Dev_sel(Dev_sel),
        .Dev_addr(Dev_addr), .Dev_wdata(Dev_wdata), .Dev_rd(Dev_rd),
        .Dev_wr(Dev_wr), .Bus_error(Bus_error)
    );

    always #5 clock = ~clock;

    task automatic test_reset();
        reset = 1'b0; IORead = 1'b0; IOWrite = 1'b0; Dev_ready = 1'b0;
        Addr_low = '0; Wdata = '0; Dev_rdata = '0;
        repeat (2) @(negedge clock);
        #1;
        obs = {Stall, Dev_rd, Dev_wr, Bus_error, Dev_sel};
        n_cmp++;
        if (obs !== 12'h000 || Rdata !== 32'h0 || Dev_wdata !== 32'h0 || Dev_addr !== 2'b00) begin
            n_bad++;
            $display("FAIL reset_outputs: got ctl=%h rdata=%h wdata=%h addr=%b want all zero",
                     obs, Rdata, Dev_wdata, Dev_addr);
        end
        @(negedge clock); reset = 1'b1;
    endtask

    // Read dev 2 word 1, ready on first WAIT cycle; DONE must not restart.
    task automatic test_read();
        int n_stall = 0;
        @(negedge clock);
        IORead = 1'b1; Addr_low = 10'h024; Dev_rdata = 32'h0000_00A5;
        for (int k = 0; k < 6; k++) begin
            if (k > 0) @(negedge clock);
            IORead    = (k <= 3);
            Dev_ready = (k == 2);
            #1;
            if (Stall === 1'b1) n_stall++;
            obs = {Stall, Dev_rd, Dev_wr, Bus_error, Dev_sel};
            if (k == 1) begin
                n_cmp++;
                if (obs !== {4'b1000, 8'b0000_0100} || Dev_addr !== 2'b01) begin
                    n_bad++;
                    $display("FAIL rd_setup: got ctl=%b addr=%b want ctl=%b addr=01", obs, Dev_addr, {4'b1000, 8'b0000_0100});
                end
            end
            if (k == 2) begin
                n_cmp++;
                if (obs !== {4'b1100, 8'b0000_0100}) begin
                    n_bad++;
                    $display("FAIL rd_wait: got ctl=%b want %b", obs, {4'b1100, 8'b0000_0100});
                end
            end
            if (k == 3) begin
                n_cmp++;
                if (obs !== 12'h000 || Rdata !== 32'h0000_00A5) begin
                    n_bad++;
                    $display("FAIL rd_done: got ctl=%b rdata=%h want ctl=0 rdata=000000a5", obs, Rdata);
                end
            end
            if (k == 4) begin
                n_cmp++;
                if (obs !== 12'h000 || Rdata !== 32'h0000_00A5) begin
                    n_bad++;
                    $display("FAIL done_no_restart: got ctl=%b rdata=%h want ctl=0 rdata=000000a5", obs, Rdata);
                end
            end
        end
        n_cmp++;
        if (n_stall != 3) begin
            n_bad++;
            $display("FAIL rd_stall_cycles: got %0d want 3", n_stall);
        end
    endtask

    // Write dev 7 word 0, ready on third WAIT cycle.
    task automatic test_write();
        int n_stall = 0;
        int n_wr = 0;
        @(negedge clock);
        IOWrite = 1'b1; Addr_low = 10'h070; Wdata = 32'h1234_5678;
        for (int k = 0; k < 8; k++) begin
            if (k > 0) @(negedge clock);
            IOWrite   = (k <= 5);
            Dev_ready = (k == 4);
            if (k == 1) Wdata = 32'hDEAD_0000;   // must not disturb latched data
            #1;
            if (Stall === 1'b1) n_stall++;
            if (Dev_wr === 1'b1) n_wr++;
            if (k == 2 || k == 4) begin
                n_cmp++;
                if (Dev_wdata !== 32'h1234_5678 || Dev_sel !== 8'h80 || Dev_addr !== 2'b00 || Dev_rd !== 1'b0) begin
                    n_bad++;
                    $display("FAIL wr_wait_k%0d: got wdata=%h sel=%b addr=%b rd=%b want 12345678 10000000 00 0",
                             k, Dev_wdata, Dev_sel, Dev_addr, Dev_rd);
                end
            end
        end
        n_cmp++;
        if (n_stall != 5) begin n_bad++; $display("FAIL wr_stall_cycles: got %0d want 5", n_stall); end
        n_cmp++;
        if (n_wr != 3) begin n_bad++; $display("FAIL wr_strobe_cycles: got %0d want 3", n_wr); end
    endtask

    // Misaligned write, both strobes, then out-of-range read.
    task automatic test_errors();
        logic [9:0]  addr_v [3] = '{10'h026, 10'h020, 10'h090};
        logic [1:0]  dir_v  [3] = '{2'b01, 2'b11, 2'b10};   // {IORead, IOWrite}
        logic [31:0] rd_v   [3] = '{32'h0000_00A5, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        for (int t = 0; t < 3; t++) begin
            int n_sel = 0;
            int n_err = 0;
            @(negedge clock);
            Addr_low = addr_v[t]; {IORead, IOWrite} = dir_v[t];
            for (int k = 0; k < 4; k++) begin
                if (k > 0) @(negedge clock);
                if (k == 2) {IORead, IOWrite} = 2'b00;
                #1;
                if (Dev_sel !== 8'h00 || Dev_wr === 1'b1 || Dev_rd === 1'b1) n_sel++;
                if (Bus_error === 1'b1) n_err++;
                if (k == 1) begin
                    n_cmp++;
                    if (Bus_error !== 1'b1 || Stall !== 1'b0 || Rdata !== rd_v[t]) begin
                        n_bad++;
                        $display("FAIL err%0d_pulse: got berr=%b stall=%b rdata=%h want 1 0 %h",
                                 t, Bus_error, Stall, Rdata, rd_v[t]);
                    end
                end
            end
            n_cmp++;
            if (n_sel != 0 || n_err != 1 || Rdata !== rd_v[t]) begin
                n_bad++;
                $display("FAIL err%0d_summary: got sel_cycles=%0d err_cycles=%0d rdata=%h want 0 1 %h",
                         t, n_sel, n_err, Rdata, rd_v[t]);
            end
        end
    endtask

    task automatic test_long_wait();
        int n_stall = 0;
        @(negedge clock);
        IORead = 1'b1; Addr_low = 10'h000; Dev_rdata = 32'h5A5A_0040;
`ifdef IO_TIMEOUT_EN
        for (int k = 0; k < 20; k++) begin
            if (k > 0) @(negedge clock);
            IORead = (k <= 17); Dev_ready = 1'b0;
            #1;
            if (Stall === 1'b1) n_stall++;
            if (k == 17) begin
                n_cmp++;
                if (Bus_error !== 1'b1 || Rdata !== 32'hFFFF_FFFF) begin
                    n_bad++;
                    $display("FAIL timeout_err: got berr=%b rdata=%h want 1 ffffffff", Bus_error, Rdata);
                end
            end
        end
        n_cmp++;
        if (n_stall != 17) begin n_bad++; $display("FAIL timeout_stall: got %0d want 17", n_stall); end
`else
        for (int k = 0; k < 44; k++) begin
            if (k > 0) @(negedge clock);
            IORead = (k <= 41); Dev_ready = (k == 40);
            #1;
            if (Stall === 1'b1) n_stall++;
            if (k == 41) begin
                n_cmp++;
                if (Stall !== 1'b0 || Bus_error !== 1'b0 || Rdata !== 32'h5A5A_0040) begin
                    n_bad++;
                    $display("FAIL long_done: got stall=%b berr=%b rdata=%h want 0 0 5a5a0040", Stall, Bus_error, Rdata);
                end
            end
        end
        n_cmp++;
        if (n_stall != 41) begin n_bad++; $display("FAIL long_stall: got %0d want 41", n_stall); end
`endif
    endtask

    // Async reset during a write WAIT, then two back-to-back reads.
    task automatic test_reset_mid_and_back_to_back();
        @(negedge clock);
        IOWrite = 1'b1; Addr_low = 10'h010; Wdata = 32'hAAAA_5555;
        repeat (2) @(negedge clock);
        #1;
        n_cmp++;
        if (Dev_wr !== 1'b1 || Dev_sel !== 8'h02) begin
            n_bad++;
            $display("FAIL rst_pre_wait: got wr=%b sel=%b want 1 00000010", Dev_wr, Dev_sel);
        end
        #1 reset = 1'b0;
        #1;
        obs = {Stall, Dev_rd, Dev_wr, Bus_error, Dev_sel};
        n_cmp++;
        if (obs !== 12'h000 || Rdata !== 32'h0 || Dev_wdata !== 32'h0 || Dev_addr !== 2'b00) begin
            n_bad++;
            $display("FAIL rst_async: got ctl=%b rdata=%h wdata=%h addr=%b want all zero", obs, Rdata, Dev_wdata, Dev_addr);
        end
        IOWrite = 1'b0;
        @(negedge clock); reset = 1'b1;
        @(negedge clock);
        IORead = 1'b1; Addr_low = 10'h03C;
        for (int k = 0; k < 9; k++) begin
            if (k > 0) @(negedge clock);
            if (k == 4) Addr_low = 10'h014;
            IORead    = (k <= 7);
            Dev_ready = (k == 2 || k == 6);
            Dev_rdata = (k < 4) ? 32'hCAFE_0001 : 32'hBEEF_0002;
            #1;
            obs = {Stall, Dev_rd, Dev_wr, Bus_error, Dev_sel};
            if (k == 1 || k == 5) begin
                n_cmp++;
                if (obs !== {4'b1000, (k == 1) ? 8'h08 : 8'h02} || Dev_addr !== ((k == 1) ? 2'b11 : 2'b01)) begin
                    n_bad++;
                    $display("FAIL b2b_setup_k%0d: got ctl=%b addr=%b", k, obs, Dev_addr);
                end
            end
            if (k == 3 || k == 7) begin
                n_cmp++;
                if (Stall !== 1'b0 || Rdata !== ((k == 3) ? 32'hCAFE_0001 : 32'hBEEF_0002)) begin
                    n_bad++;
                    $display("FAIL b2b_done_k%0d: got stall=%b rdata=%h", k, Stall, Rdata);
                end
            end
            if (k == 4) begin
                n_cmp++;
                if (Stall !== 1'b1 || Dev_sel !== 8'h00) begin
                    n_bad++;
                    $display("FAIL b2b_accept: got stall=%b sel=%b want 1 00000000", Stall, Dev_sel);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_read();
        test_write();
        test_errors();
        test_long_wait();
        test_reset_mid_and_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/io_access_sequencer.md
Name: io_access_sequencer

Overview:
- Multi-cycle sequencer between the single-cycle CPU's IORead/IOWrite strobes and a shared peripheral bus.
- IO space is the top 1 KB (address bits [31:10] all ones); this block receives the low 10 address bits.
- Decodes the target device, drives a select/strobe/ready handshake, and stalls the CPU until the access completes or faults.
- Returns read data to the write-back mux.

Parameters:
- NUM_DEV, 8, number of peripheral slots; legal device indices are 0..NUM_DEV-1.
- DEV_SHIFT, 4, log2 of the bytes per device window (16 B = 4 words).
- TIMEOUT, 15, maximum WAIT cycles before abort (used only with IO_TIMEOUT_EN).

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- IORead  in  1  CPU IO load request (level, held while Stall=1).
- IOWrite  in  1  CPU IO store request (level, held while Stall=1).
- Addr_low  in  10  ALU result [9:0], a byte address.
- Wdata  in  32  store data.
- Dev_rdata  in  32  muxed peripheral read data.
- Dev_ready  in  1  peripheral completion.
- Stall  out  1  freeze PC and register-file write.
- Rdata  out  32  IO load result.
- Dev_sel  out  NUM_DEV  one-hot device select.
- Dev_addr  out  DEV_SHIFT-2  word offset inside the device window.
- Dev_wdata  out  32  latched store data.
- Dev_rd  out  1  read strobe.
- Dev_wr  out  1  write strobe.
- Bus_error  out  1  one-cycle fault pulse.

Behaviour:
- Reset values: state IDLE, all outputs 0, counter 0. Reset asserted mid-access returns to IDLE at once and drops every strobe. No partial write is retried.
- States: IDLE, SETUP, WAIT, DONE, ERR.
- IDLE:
  - Stall = IORead | IOWrite, combinational, so the requesting instruction freezes in the same cycle.
  - On a request, latch the address, Wdata and direction.
  - Device index = Addr_low[9:DEV_SHIFT].
  - If the index is >= NUM_DEV, Addr_low[1:0] != 0, or IORead and IOWrite are both high, go to ERR. Otherwise go to SETUP.
- SETUP (1 cycle):
  - Drive Dev_sel one-hot, Dev_addr = Addr_low[DEV_SHIFT-1:2], and Dev_wdata.
  - Dev_rd and Dev_wr stay 0. Stall=1. Go to WAIT.
- WAIT:
  - Dev_sel held; Dev_rd or Dev_wr held high according to direction; Stall=1; counter increments each cycle.
  - If Dev_ready=1: on a read, Rdata <= Dev_rdata; go to DONE.
  - Dev_ready is ignored in every other state.
- DONE (1 cycle):
  - Stall=0, strobes and Dev_sel at 0, Rdata valid, so the instruction retires at this edge.
  - Go to IDLE unconditionally. The still-high IORead/IOWrite of the retiring instruction is not re-accepted.
  - A new request is accepted one cycle later, in IDLE.
- ERR (1 cycle):
  - Bus_error=1 and Stall=0.
  - On a read, Rdata <= 32'hFFFF_FFFF; on a write, nothing is written. Go to IDLE.
- Rdata holds its last value between accesses.
- Minimum latency: request cycle + SETUP + WAIT(1) + DONE = 4 cycles; Stall is high for 3 of them.
- The counter is $clog2(TIMEOUT+1) bits, cleared on entering WAIT, and saturates (no wrap).

Optional Feature:
- Macro: IO_TIMEOUT_EN.
- Defined: in WAIT, if the counter reaches TIMEOUT with Dev_ready=0, go to ERR. Dev_ready arriving in that same cycle wins and goes to DONE.
- Undefined: no counter logic; WAIT holds indefinitely until Dev_ready.

Test Plan:
- Read, Addr_low=10'h024 (device 2, word 1), Dev_ready high on the 1st WAIT cycle, Dev_rdata=32'h0000_00A5 -> Dev_sel=8'b0000_0100, Dev_addr=2'b01, Stall high 3 cycles, Rdata=32'h0000_00A5 in DONE.
- Write, Addr_low=10'h070, Wdata=32'h1234_5678, Dev_ready after 3 WAIT cycles -> Dev_wr high for exactly 3 cycles, Dev_wdata stable, Stall high 5 cycles.
- Addr_low=10'h090 (index 9 >= 8) -> ERR next cycle, Bus_error pulse, Rdata=32'hFFFF_FFFF, Dev_sel never asserted.
- With IO_TIMEOUT_EN, Dev_ready held 0 -> ERR after 15 WAIT cycles. Without the macro -> Stall stays high until Dev_ready is raised at cycle 40, then normal DONE.
- Reset pulled low during WAIT with Dev_wr=1 -> all outputs 0 immediately (asynchronously). After release, a back-to-back read is accepted normally.
- IORead held high through DONE with no new instruction -> no second access is started from DONE.
